// File: rtl/conv_psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : conv_psum_buffer
// Description : Partial-sum buffer for conv2 output; accumulates CHAN channels
//               into an OUT_H x OUT_W array, then ReLU + 8-bit quantises.
//               Optional macro PSUM_SAT_EN: saturating add and 8-bit clamp.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_psum_buffer #(
   parameter int OUT_H = 12,
   parameter int OUT_W = 11,
   parameter int CHAN  = 10,
   parameter int IN_W  = 24,
   parameter int ACC_W = 24,
   parameter int SHIFT = 0
) (
   input  logic                          clk,
   input  logic                          rst_ni,
   input  logic                          clear,
   input  logic                          ce,
   input  logic                          in_valid,
   input  logic [7:0]                    in_addr,
   input  logic signed [IN_W-1:0]        in_data,
   output logic [OUT_H*OUT_W*8-1:0]      out_data,
   output logic                          out_valid,
   output logic [3:0]                    chan_cnt,
   output logic [7:0]                    pix_cnt,
   output logic                          busy,
   output logic                          addr_err
);

   localparam int N = OUT_H * OUT_W;
   localparam logic [7:0] N_ADDR    = 8'(N);
   localparam logic [7:0] LAST_PIX  = 8'(N - 1);
   localparam logic [3:0] LAST_CHAN = 4'(CHAN - 1);
   localparam logic signed [ACC_W-1:0] ZERO = '0;
   localparam logic signed [ACC_W-1:0] MAX8 = ACC_W'(255);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   logic signed [ACC_W-1:0] acc [N];

   logic                    in_range;
   logic                    wr_req;
   logic                    accept;
   logic                    pix_wrap;
   logic                    img_last;
   logic [7:0]              rd_addr;
   logic signed [ACC_W-1:0] acc_sel;
   logic signed [ACC_W-1:0] in_ext;
   logic signed [ACC_W-1:0] sum;

   assign in_range = (in_addr < N_ADDR);
   assign wr_req   = ce & in_valid & (state != DONE);
   assign accept   = wr_req & in_range & ~clear;
   assign pix_wrap = (pix_cnt == LAST_PIX);
   assign img_last = accept & pix_wrap & (chan_cnt == LAST_CHAN);

   // Out-of-range addresses never write, so the read port just parks on 0.
   assign rd_addr  = in_range ? in_addr : 8'd0;
   assign acc_sel  = acc[rd_addr];
   assign in_ext   = ACC_W'(in_data);

`ifdef PSUM_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   logic signed [ACC_W:0] sum_wide;

   always_comb begin
      sum_wide = {acc_sel[ACC_W-1], acc_sel} + {in_ext[ACC_W-1], in_ext};
      sum      = sum_wide[ACC_W-1:0];
      if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
         sum = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
      end
   end
`else
   always_comb begin
      sum = acc_sel + in_ext;
   end
`endif

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state_nxt = img_last ? DONE : ACCUM;
               end
            end
            ACCUM: begin
               if (img_last) begin
                  state_nxt = DONE;
               end
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   assign busy      = (state == ACCUM);
   assign out_valid = (state == DONE);

   // ------------------------------------------------------------ counters
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         pix_cnt  <= 8'd0;
         chan_cnt <= 4'd0;
         addr_err <= 1'b0;
      end else if (clear) begin
         pix_cnt  <= 8'd0;
         chan_cnt <= 4'd0;
         addr_err <= 1'b0;
      end else begin
         if (wr_req && !in_range) begin
            addr_err <= 1'b1;
         end
         if (accept) begin
            if (pix_wrap) begin
               pix_cnt  <= 8'd0;
               chan_cnt <= chan_cnt + 4'd1;
            end else begin
               pix_cnt  <= pix_cnt + 8'd1;
            end
         end
      end
   end

   // ------------------------------------------------------ partial sums
   // Channel 0 overwrites, so a stale array never needs explicit zeroing.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N; i++) begin
            acc[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 0; i < N; i++) begin
            acc[i] <= '0;
         end
      end else if (accept) begin
         acc[rd_addr] <= (chan_cnt == 4'd0) ? in_ext : sum;
      end
   end

   // ------------------------------------------------- ReLU + quantise
   for (genvar i = 0; i < N; i++) begin : g_out
      logic signed [ACC_W-1:0] v;
      assign v = acc[i] >>> SHIFT;
`ifdef PSUM_SAT_EN
      assign out_data[i*8 +: 8] = (v < ZERO) ? 8'd0 :
                                  (v > MAX8) ? 8'hff : v[7:0];
`else
      assign out_data[i*8 +: 8] = (v < ZERO) ? 8'd0 : v[7:0];
`endif
   end

endmodule
`default_nettype wire

// File: tb/tb_conv_psum_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_psum_buffer
// Description : Self-checking bench for conv_psum_buffer with a scoreboard of
//               expected feature vectors and directed register checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_psum_buffer;

   localparam int N    = 132;
   localparam int CHAN = 10;

   typedef struct {
      string            name;
      logic [N*8-1:0]   img;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_ni = 1'b0;
   logic              clear = 1'b0;
   logic              ce = 1'b0;
   logic              in_valid = 1'b0;
   logic [7:0]        in_addr = 8'd0;
   logic signed [23:0] in_data = 24'sd0;
   logic [N*8-1:0]    out_data;
   logic              out_valid;
   logic [3:0]        chan_cnt;
   logic [7:0]        pix_cnt;
   logic              busy;
   logic              addr_err;

   exp_t              sbq[$];
   int                vec_cnt = 0;
   int                err_cnt = 0;
   logic [N*8-1:0]    expv;

   conv_psum_buffer dut (
      .clk       (clk),
      .rst_ni    (rst_ni),
      .clear     (clear),
      .ce        (ce),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_data   (in_data),
      .out_data  (out_data),
      .out_valid (out_valid),
      .chan_cnt  (chan_cnt),
      .pix_cnt   (pix_cnt),
      .busy      (busy),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input int d);
      in_valid = 1'b1;
      in_addr  = 8'(a);
      in_data  = 24'(d);
      tick();
      in_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_vec(input string nm, input logic [N*8-1:0] exp);
      int bad;
      bad = -1;
      vec_cnt++;
      for (int i = N - 1; i >= 0; i--) begin
         if (out_data[i*8 +: 8] !== exp[i*8 +: 8]) bad = i;
      end
      if (bad >= 0) begin
         err_cnt++;
         $display("FAIL %s: out_data[%0d] got %0d expected %0d", nm, bad,
                  out_data[bad*8 +: 8], exp[bad*8 +: 8]);
      end
   endtask

   // Monitor: each rising out_valid presents a vector checked against the queue.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         if (out_valid && !prev) begin
            if (sbq.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL unexpected_out_valid: got 1 expected 0");
            end else begin
               e = sbq.pop_front();
               chk_vec(e.name, e.img);
            end
         end
         prev = out_valid;
      end
   end

   initial begin
      // ---------------- reset state
      #12;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_chan_cnt", 32'(chan_cnt), 0);
      chk("rst_pix_cnt", 32'(pix_cnt), 0);
      chk("rst_addr_err", 32'(addr_err), 0);
      chk_vec("rst_out_data", '0);
      rst_ni = 1'b1;
      ce     = 1'b1;
      tick();

      // ---------------- 1: all ones over 10 channels
      for (int i = 0; i < N; i++) expv[i*8 +: 8] = 8'd10;
      sbq.push_back('{name: "img_all_ones", img: expv});
      for (int c = 0; c < CHAN; c++) begin
         for (int a = 0; a < N; a++) begin
            if (c == CHAN - 1 && a == N - 1)
               chk("t1_valid_before_last", 32'(out_valid), 0);
            wr(a, 1);
         end
         if (c == 0) chk("t1_busy", 32'(busy), 1);
      end
      chk("t1_out_valid", 32'(out_valid), 1);
      chk("t1_chan_cnt", 32'(chan_cnt), 10);
      chk("t1_busy_done", 32'(busy), 0);
      chk("t1_pix_cnt", 32'(pix_cnt), 0);

      // ---------------- 2: ReLU of negative sum
      do_clear();
      chk("t2_clear_valid", 32'(out_valid), 0);
      sbq.push_back('{name: "img_relu", img: '0});
      for (int c = 0; c < CHAN; c++) begin
         for (int a = 0; a < N; a++) wr(a, (a != 0) ? 0 : ((c == 0) ? 5 : -1));
         if (c == 1) chk("t2_acc0_after_ch1", 32'(out_data[7:0]), 4);
      end
      chk("t2_out_valid", 32'(out_valid), 1);

      // ---------------- 3: out-of-range address
      do_clear();
      for (int a = 0; a < 5; a++) wr(a, 9);
      chk("t3_pix_before", 32'(pix_cnt), 5);
      wr(200, 99);
      chk("t3_addr_err", 32'(addr_err), 1);
      chk("t3_pix_after", 32'(pix_cnt), 5);
      expv = '0;
      for (int a = 0; a < 5; a++) expv[a*8 +: 8] = 8'd9;
      chk_vec("t3_array_unchanged", expv);
      do_clear();
      chk("t3_addr_err_cleared", 32'(addr_err), 0);

      // ---------------- 4: clear beats a simultaneous write
      wr(3, 50);
      chk("t4_acc3_before", 32'(out_data[3*8 +: 8]), 50);
      chk("t4_busy_before", 32'(busy), 1);
      clear    = 1'b1;
      in_valid = 1'b1;
      in_addr  = 8'd3;
      in_data  = 24'sd7;
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("t4_acc3_after", 32'(out_data[3*8 +: 8]), 0);
      chk("t4_busy_after", 32'(busy), 0);
      chk("t4_pix_cnt", 32'(pix_cnt), 0);

      // ---------------- 6: 300 in addr 0, with a ce=0 window
      for (int a = 0; a < N; a++) expv[a*8 +: 8] = 8'(10 * (a % 20));
`ifdef PSUM_SAT_EN
      expv[7:0] = 8'd255;
`else
      expv[7:0] = 8'd44;
`endif
      sbq.push_back('{name: "img_quant", img: expv});
      for (int c = 0; c < CHAN; c++) begin
         for (int a = 0; a < N; a++) begin
            if (c == 4 && a == 60) begin
               ce = 1'b0;
               for (int k = 0; k < 5; k++) wr(0, 100);
               chk("t6_ce_pix_held", 32'(pix_cnt), 60);
               chk("t6_ce_acc0_held", 32'(out_data[7:0]), 150);
               chk("t6_ce_chan_held", 32'(chan_cnt), 4);
               ce = 1'b1;
            end
            wr(a, (a == 0) ? 30 : (a % 20));
         end
      end
      chk("t6_out_valid", 32'(out_valid), 1);

      // ---------------- 5: writes after DONE are ignored
      for (int k = 0; k < 20; k++) wr(k, 50);
      wr(200, 1);
      chk("t5_out_valid", 32'(out_valid), 1);
      chk("t5_chan_cnt", 32'(chan_cnt), 10);
      chk("t5_pix_cnt", 32'(pix_cnt), 0);
      chk("t5_addr_err", 32'(addr_err), 0);
      chk_vec("t5_array_held", expv);

      // ---------------- reset mid-image
      do_clear();
      for (int a = 0; a < 7; a++) wr(a, 3);
      rst_ni = 1'b0;
      #2;
      chk("rst_mid_pix", 32'(pix_cnt), 0);
      chk_vec("rst_mid_array", '0);
      rst_ni = 1'b1;
      tick();

      repeat (3) tick();
      chk("scoreboard_drained", 32'(sbq.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/conv_psum_buffer.md
Name: conv_psum_buffer

Overview:
- Sits directly downstream of the conv engine and upstream of the fcn.
- Accumulates the conv2 per-channel output pixels, each a signed 24-bit value tagged with a pixel address, into a 12x11 partial-sum array across CHAN input channels.
- After the last channel it applies ReLU and 8-bit quantisation, then presents the flattened feature vector to the fcn with a valid flag.

Parameters:
- OUT_H, 12, feature-map rows
- OUT_W, 11, feature-map columns
- CHAN, 10, input channels accumulated per image
- IN_W, 24, input pixel width (signed)
- ACC_W, 24, accumulator width (signed)
- SHIFT, 0, right arithmetic shift applied before 8-bit quantisation

Ports:
- clk  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- clear  in  1  synchronous clear pulse: zero array, counters, state
- ce  in  1  accumulate enable (conv2 layer active); writes ignored when low
- in_valid  in  1  in_data/in_addr valid this cycle
- in_addr  in  8  flat pixel index, row*OUT_W+col
- in_data  in  IN_W  signed conv pixel
- out_data  out  OUT_H*OUT_W x 8  unsigned ReLU'd features, flat index order
- out_valid  out  1  feature vector complete and stable
- chan_cnt  out  4  channels completed so far
- pix_cnt  out  8  accepted pixels in current channel
- busy  out  1  state is ACCUM
- addr_err  out  1  sticky: out-of-range in_addr seen since last clear

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_ni.
- Reset values: acc array, chan_cnt, pix_cnt, out_valid, busy and addr_err are all 0; state is IDLE.
- N = OUT_H*OUT_W (132).
- Accepted write: ce & in_valid & in_addr<N & state!=DONE.
- If in_addr>=N with ce & in_valid: no array write, pix_cnt unchanged, addr_err<=1.
- States:
  - IDLE: first accepted write goes to ACCUM.
  - ACCUM: after accepting the Nth pixel of channel CHAN-1, go to DONE.
  - DONE: stays until clear.
- Accumulate rule, 1-cycle latency (acc visible the cycle after the write):
  - chan_cnt==0: acc[a] <= sign-extend(in_data). The first channel overwrites, so no pre-zero dependency.
  - otherwise: acc[a] <= acc[a] + in_data, in ACC_W bits.
- Counting:
  - pix_cnt increments per accepted write.
  - When an accepted write arrives with pix_cnt==N-1: pix_cnt<=0 and chan_cnt<=chan_cnt+1.
  - When that write lands in channel CHAN-1: state<=DONE and out_valid<=1 in the same edge.
- Duplicate addresses within a channel are not detected; they still count toward pix_cnt.
- out_data[i]: combinational from acc[i].
  - Let v = acc[i]>>>SHIFT.
  - v<0 gives 0; otherwise v[7:0] (see optional feature).
  - Only guaranteed meaningful while out_valid=1.
- In DONE, in_valid is ignored. The array holds, out_valid stays 1 and no counters move.
- clear:
  - Next edge: acc zeroed, chan_cnt=pix_cnt=0, out_valid=0, addr_err=0, state IDLE.
  - clear takes priority over a simultaneous write; that write is dropped.
- ce low mid-image: writes ignored, all state held. Accumulation resumes when ce returns high.
- Reset mid-image: asynchronous return to reset values; a partial image is lost.
- busy = (state==ACCUM).

Optional Feature:
- Macro: PSUM_SAT_EN.
- Defined:
  - The accumulator add saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Quantisation clamps: v>255 gives 255.
- Undefined:
  - The add wraps modulo 2^ACC_W.
  - Quantisation truncates to v[7:0] after ReLU.

Test Plan:
1. Reset, then CHAN=10 channels each writing in_data=+1 to all 132 addresses in order.
   - Required: out_valid rises the cycle after the 1320th write; every out_data=10; chan_cnt=10; busy=0.
2. Channel 0 writes 5 to addr 0; channels 1..9 write -1 to addr 0; all other addresses 0.
   - Required: acc[0]=-4, out_data[0]=0 (ReLU), all others 0.
3. in_valid with in_addr=200 mid-channel.
   - Required: addr_err=1, pix_cnt unchanged, no array change; clear then drops addr_err to 0.
4. clear asserted in the same cycle as a write to addr 3 of value 7.
   - Required: next cycle acc[3]=0, state IDLE, pix_cnt=0.
5. After DONE, drive 20 further valid writes.
   - Required: out_data and out_valid unchanged; chan_cnt stays 10.
6. Drive acc[0] to 300 over 10 channels (30 each).
   - PSUM_SAT_EN defined: out_data[0]=255.
   - Undefined: out_data[0]=44.
   - Also: ce=0 for 5 cycles mid-channel; writes during that window are ignored.
